// File: rtl/reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_arbiter
// Brief    : Round-robin arbiter sharing one register-interface target among
//            NUM_REQ requesters, one transaction at a time. Optional BUSY
//            timeout abort enabled by the macro REG_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
// Packed layouts, MSB first:
//   request  : {addr, write, wdata, wstrb, valid}  (valid at bit 0)
//   response : {rdata, error, ready}               (ready at bit 0)
module reg_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int c_STRB_WIDTH  = DATA_WIDTH / 8,
    localparam int c_REQ_WIDTH   = ADDR_WIDTH + DATA_WIDTH + c_STRB_WIDTH + 2,
    localparam int c_RSP_WIDTH   = DATA_WIDTH + 2,
    localparam int c_IDX_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ*c_REQ_WIDTH-1:0] req_i,
    output logic [NUM_REQ*c_RSP_WIDTH-1:0] rsp_o,
    output logic [c_REQ_WIDTH-1:0]         reg_req_o,
    input  logic [c_RSP_WIDTH-1:0]         reg_rsp_i,
    output logic [c_IDX_WIDTH-1:0]         gnt_idx_o,
    output logic                           busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_IDX_WIDTH-1:0]   r_gnt_idx;
    logic [c_IDX_WIDTH-1:0]   w_gnt_nxt;
    logic [c_IDX_WIDTH-1:0]   r_rr_ptr;
    logic [c_IDX_WIDTH-1:0]   w_rr_nxt;
    logic [c_IDX_WIDTH-1:0]   w_winner;
    logic [c_IDX_WIDTH-1:0]   w_cand;
    logic                     w_found;
    logic                     w_busy;
    logic                     w_timeout;
    logic                     w_owner_valid;
    logic [c_REQ_WIDTH-1:0]   w_owner_req;
    logic [c_RSP_WIDTH-1:0]   w_rsp_owner;
    logic [c_REQ_WIDTH-1:0]   w_req [NUM_REQ];
    logic [NUM_REQ-1:0]       w_valid;

    if (NUM_REQ < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("reg_arbiter: NUM_REQ must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_req[k]   = req_i[k*c_REQ_WIDTH +: c_REQ_WIDTH];
        assign w_valid[k] = w_req[k][0];
    end

    // (base + offset) mod NUM_REQ without a divider; offset is always < NUM_REQ
    function automatic logic [c_IDX_WIDTH-1:0] f_wrap_inc(
        input logic [c_IDX_WIDTH-1:0] base,
        input int                     offset
    );
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[c_IDX_WIDTH-1:0];
    endfunction

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = f_wrap_inc(r_rr_ptr, i);
            if (!w_found && w_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_busy        = (r_state == ST_BUSY);
    assign w_owner_req   = w_req[r_gnt_idx];
    assign w_owner_valid = w_owner_req[0];

`ifdef REG_ARBITER_TIMEOUT_EN
    localparam int c_CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic [c_CNT_WIDTH-1:0] r_cnt;

    // Idle clears the counter, so every BUSY entry starts from zero
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_busy) begin
            r_cnt <= '0;
        end else if (!reg_rsp_i[0]) begin
            r_cnt <= r_cnt + c_CNT_WIDTH'(1);
        end
    end

    assign w_timeout = w_busy && !reg_rsp_i[0]
                       && (r_cnt == c_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_rsp_owner = reg_rsp_i;
        if (w_timeout) begin
            w_rsp_owner = {{DATA_WIDTH{1'b0}}, 2'b11};
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
        assign rsp_o[k*c_RSP_WIDTH +: c_RSP_WIDTH] =
            (w_busy && (r_gnt_idx == c_IDX_WIDTH'(k))) ? w_rsp_owner : '0;
    end

    assign reg_req_o = w_busy ? w_owner_req : '0;
    assign gnt_idx_o = r_gnt_idx;
    assign busy_o    = w_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = w_winner;
                end
            end
            ST_BUSY: begin
                // A withdrawn request releases the port without moving the pointer
                if (!w_owner_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (reg_rsp_i[0] || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = f_wrap_inc(r_gnt_idx, 1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_rr_ptr  <= w_rr_nxt;
        end
    end

    a_owner_holds_valid: assert property (
        @(posedge clk_i) disable iff (rst_i) w_busy |-> w_owner_valid
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_arbiter
// Brief    : Self-checking bench for reg_arbiter with an owner/pointer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_arbiter;
    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int TO    = 8;
    localparam int REQ_W = AW + DW + SW + 2;
    localparam int RSP_W = DW + 2;
    localparam int IW    = 2;
    localparam int ALL_W = 1 + IW + REQ_W + N * RSP_W;
`ifdef REG_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N*REQ_W-1:0] req_i;
    logic [N*RSP_W-1:0] rsp_o;
    logic [REQ_W-1:0]   reg_req_o;
    logic [RSP_W-1:0]   reg_rsp_i;
    logic [IW-1:0]      gnt_idx_o;
    logic               busy_o;

    reg_arbiter #(
        .NUM_REQ       (N),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req_i),
        .rsp_o    (rsp_o),
        .reg_req_o(reg_req_o),
        .reg_rsp_i(reg_rsp_i),
        .gnt_idx_o(gnt_idx_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] a_addr  [N];
    logic          a_write [N];
    logic [DW-1:0] a_wdata [N];
    logic [SW-1:0] a_wstrb [N];
    logic          a_valid [N];
    logic          s_new   [N];
    logic [AW-1:0] s_addr  [N];
    logic          s_write [N];
    int            pend    [N];

    logic          t_ready;
    logic          t_error;
    logic [DW-1:0] t_rdata;
    assign reg_rsp_i = {t_rdata, t_error, t_ready};

    // Model: owner (-1 = idle), last owner, pointer, BUSY cycle number (1-based)
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_cyc   = 0;
    int m_lat   = 0;
    int m_done  = -1;
    int lat_lo  = 0;
    int lat_hi  = 0;
    int n_vec   = 0;
    int n_err   = 0;
    int dut_grants[$];
    logic prev_busy = 1'b0;

    function automatic logic [REQ_W-1:0] pack_req(input int k);
        return {a_addr[k], a_write[k], a_wdata[k], a_wstrb[k], a_valid[k]};
    endfunction

    always_comb begin
        req_i = '0;
        for (int k = 0; k < N; k++) begin
            req_i[k*REQ_W +: REQ_W] = pack_req(k);
        end
    end

    function automatic logic [DW-1:0] tdata(input logic [AW-1:0] addr);
        return {16'hCAFE, addr[19:4]};
    endfunction

    function automatic bit abort_now();
        return TMO_EN && (m_owner >= 0) && (m_cyc == TO) && !t_ready;
    endfunction

    function automatic logic [ALL_W-1:0] exp_all();
        logic [REQ_W-1:0]   rq;
        logic [N*RSP_W-1:0] rs;
        logic [IW-1:0]      gi;
        rq = '0;
        rs = '0;
        gi = IW'(m_last);
        if (m_owner >= 0) begin
            rq = pack_req(m_owner);
            rs[m_owner*RSP_W +: RSP_W] = abort_now() ? {{DW{1'b0}}, 2'b11}
                                                     : {t_rdata, t_error, t_ready};
        end
        return {(m_owner >= 0) ? 1'b1 : 1'b0, gi, rq, rs};
    endfunction

    function automatic bit drained();
        bit d;
        d = (m_owner < 0);
        for (int k = 0; k < N; k++) begin
            if (a_valid[k] || s_new[k]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic stage(input int k, input logic [AW-1:0] addr, input logic wr);
        s_new[k]   = 1'b1;
        s_addr[k]  = addr;
        s_write[k] = wr;
    endtask

    task automatic load_next(input int k);
        if (pend[k] > 0) begin
            pend[k]--;
            a_addr[k]  = $urandom & 32'hFFFF_FFFC;
            a_write[k] = 1'($urandom);
            a_wdata[k] = $urandom;
            a_wstrb[k] = SW'($urandom);
            a_valid[k] = 1'b1;
        end else begin
            a_addr[k]  = '0;
            a_write[k] = 1'b0;
            a_wdata[k] = '0;
            a_wstrb[k] = '0;
            a_valid[k] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs just after the edge, return at the falling edge
    task automatic step(input logic r);
        @(posedge clk);
        #1;
        rst = r;
        if (m_done >= 0) load_next(m_done);
        for (int k = 0; k < N; k++) begin
            if (s_new[k]) begin
                a_addr[k]  = s_addr[k];
                a_write[k] = s_write[k];
                a_wdata[k] = $urandom;
                a_wstrb[k] = SW'($urandom);
                a_valid[k] = 1'b1;
                s_new[k]   = 1'b0;
            end
        end
        if (m_owner >= 0 && m_cyc == m_lat + 1) begin
            t_ready = 1'b1;
            t_error = 1'b0;
            t_rdata = tdata(a_addr[m_owner]);
        end else begin
            t_ready = 1'b0;
            t_error = 1'($urandom);
            t_rdata = $urandom;
        end
        @(negedge clk);
        if (busy_o === 1'b1 && prev_busy !== 1'b1) dut_grants.push_back(int'(gnt_idx_o));
        prev_busy = busy_o;
    endtask

    task automatic advance();
        int k;
        m_done = -1;
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (m_owner < 0 && a_valid[k]) begin
                    m_owner = k;
                    m_last  = k;
                    m_cyc   = 1;
                    m_lat   = int'($urandom_range(lat_hi, lat_lo));
                end
            end
        end else if (!a_valid[m_owner]) begin
            m_owner = -1;
        end else if (t_ready || abort_now()) begin
            m_done  = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_cyc++;
        end
    endtask

    task automatic test_reset();
        step(1'b1); advance();
        step(1'b1); advance();
        step(1'b0);
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_vec++;
        if (gnt_idx_o !== '0) begin n_err++; $display("FAIL reset_gnt: got %0d want 0", gnt_idx_o); end
        n_vec++;
        if (reg_req_o !== '0) begin n_err++; $display("FAIL reset_req: got %h want 0", reg_req_o); end
        n_vec++;
        if (rsp_o !== '0) begin n_err++; $display("FAIL reset_rsp: got %h want 0", rsp_o); end
        advance();
    endtask

    task automatic test_single();
        lat_lo = 0; lat_hi = 0;
        stage(2, 32'h10, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(1'b0);
            n_vec++;
            if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                n_err++;
                $display("FAIL single c%0d: got %h want %h", c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
            end
            if (c == 1) begin
                n_vec++;
                if (rsp_o[2*RSP_W +: RSP_W] !== {32'hCAFE0001, 2'b01}) begin
                    n_err++;
                    $display("FAIL single_rsp2: got %h want %h", rsp_o[2*RSP_W +: RSP_W], {32'hCAFE0001, 2'b01});
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        lat_lo = 0; lat_hi = 2;
        dut_grants.delete();
        stage(1, $urandom & 32'hFFFF_FFFC, 1'b1);
        stage(3, $urandom & 32'hFFFF_FFFC, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0);
            n_vec++;
            if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                n_err++;
                $display("FAIL wrap c%0d: got %h want %h", c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
            end
            advance();
        end
        n_vec++;
        if (dut_grants.size() != 2 || dut_grants[0] != 3 || dut_grants[1] != 1) begin
            n_err++;
            $display("FAIL wrap_order: got %0d grants first %0d,%0d want 3,1",
                     dut_grants.size(), dut_grants[0], dut_grants[1]);
        end
    endtask

    task automatic test_all_four();
        int c;
        int want[5] = '{0, 1, 2, 3, 0};
        lat_lo = 3; lat_hi = 3;
        step(1'b1); advance();
        dut_grants.delete();
        for (int k = 0; k < N; k++) stage(k, $urandom & 32'hFFFF_FFFC, 1'($urandom));
        pend[0] = 1;
        c = 0;
        do begin
            step(1'b0);
            n_vec++;
            if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                n_err++;
                $display("FAIL all4 c%0d: got %h want %h", c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
            end
            advance();
            c++;
        end while (!drained() && c < 100);
        n_vec++;
        if (!drained()) begin n_err++; $display("FAIL all4_bound: got %0d cycles want drain", c); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_grants.size() <= i || dut_grants[i] != want[i]) begin
                n_err++;
                $display("FAIL all4_grant%0d: got %0d want %0d", i,
                         (dut_grants.size() > i) ? dut_grants[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_reset_busy();
        lat_lo = 1000; lat_hi = 1000;
        stage(1, $urandom & 32'hFFFF_FFFC, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0);
            n_vec++;
            if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                n_err++;
                $display("FAIL rstbusy c%0d: got %h want %h", c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
            end
            advance();
        end
        step(1'b1);
        n_vec++;
        if (rsp_o[RSP_W] !== 1'b0) begin n_err++; $display("FAIL rstbusy_ready: got %b want 0", rsp_o[RSP_W]); end
        advance();
        lat_lo = 0; lat_hi = 0;
        stage(0, $urandom & 32'hFFFF_FFFC, 1'b1);
        dut_grants.delete();
        step(1'b0);
        n_vec++;
        if (reg_req_o[0] !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rstbusy_after: got valid %b busy %b want 0 0", reg_req_o[0], busy_o);
        end
        advance();
        for (int c = 0; c < 8; c++) begin
            step(1'b0);
            n_vec++;
            if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                n_err++;
                $display("FAIL rstbusy_post c%0d: got %h want %h", c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
            end
            advance();
        end
        n_vec++;
        if (dut_grants.size() < 1 || dut_grants[0] != 0) begin
            n_err++;
            $display("FAIL rstbusy_grant: got %0d want 0", (dut_grants.size() > 0) ? dut_grants[0] : -1);
        end
    endtask

    task automatic test_random();
        int c;
        lat_lo = 0; lat_hi = TMO_EN ? 11 : 3;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                pend[k] = int'($urandom_range(3, 0));
                if (pend[k] > 0) begin
                    pend[k]--;
                    stage(k, $urandom & 32'hFFFF_FFFC, 1'($urandom));
                end
            end
            c = 0;
            do begin
                step(1'b0);
                n_vec++;
                if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                    n_err++;
                    $display("FAIL random r%0d c%0d: got %h want %h", r, c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
                end
                advance();
                c++;
            end while (!drained() && c < 400);
            n_vec++;
            if (!drained()) begin n_err++; $display("FAIL random_bound r%0d: got %0d cycles want drain", r, c); end
        end
    endtask

`ifdef REG_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        step(1'b1); advance();
        for (int pass = 0; pass < 2; pass++) begin
            lat_lo = (pass == 0) ? 1000 : TO - 1;
            lat_hi = lat_lo;
            dut_grants.delete();
            if (pass == 0) begin
                stage(0, $urandom & 32'hFFFF_FFFC, 1'b0);
                stage(2, $urandom & 32'hFFFF_FFFC, 1'b0);
            end else begin
                stage(3, $urandom & 32'hFFFF_FFFC, 1'b0);
            end
            c = 0;
            do begin
                step(1'b0);
                n_vec++;
                if ({busy_o, gnt_idx_o, reg_req_o, rsp_o} !== exp_all()) begin
                    n_err++;
                    $display("FAIL tmo p%0d c%0d: got %h want %h", pass, c, {busy_o, gnt_idx_o, reg_req_o, rsp_o}, exp_all());
                end
                if (m_owner >= 0 && m_cyc == TO) begin
                    n_vec++;
                    if (rsp_o[m_owner*RSP_W +: RSP_W] !== ((pass == 0) ? {{DW{1'b0}}, 2'b11}
                                                           : {tdata(a_addr[m_owner]), 2'b01})) begin
                        n_err++;
                        $display("FAIL tmo_rsp p%0d: got %h", pass, rsp_o[m_owner*RSP_W +: RSP_W]);
                    end
                end
                advance();
                c++;
            end while (!drained() && c < 60);
            n_vec++;
            if (!drained()) begin n_err++; $display("FAIL tmo_bound p%0d: got %0d cycles want drain", pass, c); end
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < N; k++) begin
            a_addr[k] = '0; a_write[k] = 1'b0; a_wdata[k] = '0; a_wstrb[k] = '0;
            a_valid[k] = 1'b0; s_new[k] = 1'b0; s_addr[k] = '0; s_write[k] = 1'b0;
            pend[k] = 0;
        end
        t_ready = 1'b0;
        t_error = 1'b0;
        t_rdata = '0;
        test_reset();
        test_single();
        test_wrap();
        test_all_four();
        test_reset_busy();
        test_random();
`ifdef REG_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
